rob_commit_ctrl: RTL and testbench

In-order reorder-buffer controller that sequences the register rename table. It accepts issued instructions and drives the rename table's issue write port (`new_name_in`/`new_name_index`). It marks entries complete from common-data-bus broadcasts and retires the oldest complete entry each cycle, driving the table's commit port (`commit`/`to_zero_index`/`original_name`). It sits between the instruction handler, the CDB and the rename table.

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_ptr_ctr.sv | 25 ++
 rtl/rob_commit_ctrl.sv | 135 +++++++++++++
 tb/tb_rob_commit_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared defaults and the entry payload type for the reorder-buffer commit controller.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned ROB_REG_W = 5;

    localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 has_dest;
        logic [ROB_REG_W-1:0] dest;
        logic [ROB_TAG_W-1:0] tag;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrapping ring pointer with increment enable and synchronous clear.
module rob_ptr_ctr #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // DEPTH is a power of two, so natural overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB sequencing the rename table's issue and commit ports.
// Optional macro ROB_FLUSH_EN adds a synchronous flush input.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = rob_pkg::ROB_DEPTH,
    parameter int unsigned TAG_W = rob_pkg::ROB_TAG_W,
    parameter int unsigned REG_W = rob_pkg::ROB_REG_W
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ROB_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic                     alloc_has_dest,
    input  logic [REG_W-1:0]         alloc_dest,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    output logic [TAG_W-1:0]         new_name_in,
    output logic [REG_W-1:0]         new_name_index,
    output logic                     commit,
    output logic [REG_W-1:0]         to_zero_index,
    output logic [TAG_W-1:0]         original_name,
    output logic                     retire,
    output logic [$clog2(DEPTH):0]   rob_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rob_entry_t       entries [DEPTH];
    rob_entry_t       head_ent;
    rob_entry_t       new_ent;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             flush_now;
    logic             fire;

`ifdef ROB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign head_ent    = entries[head];
    assign alloc_ready = (count != CNT_W'(DEPTH)) && !flush_now;
    assign fire        = alloc_valid && alloc_ready;
    assign retire      = head_ent.valid && head_ent.done && !flush_now;
    assign rob_count   = count;

    // Issue port: rename table writes every cycle, so idle cycles rewrite x0 with 0.
    always_comb begin
        new_name_index = '0;
        new_name_in    = '0;
        if (fire && alloc_has_dest) begin
            new_name_index = alloc_dest;
            new_name_in    = alloc_tag;
        end
    end

    // Commit port from registered head state only.
    always_comb begin
        commit        = 1'b0;
        to_zero_index = '0;
        original_name = '0;
        if (retire && head_ent.has_dest && (head_ent.dest != '0)) begin
            commit        = 1'b1;
            to_zero_index = REG_W'(head_ent.dest);
            original_name = TAG_W'(head_ent.tag);
        end
    end

    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.done     = 1'b0;
        new_ent.has_dest = alloc_has_dest;
        new_ent.dest     = ROB_REG_W'(alloc_dest);
        new_ent.tag      = ROB_TAG_W'(alloc_tag);
    end

    // Only entries valid at the start of the cycle can be marked by the CDB;
    // head==tail with both retire and fire is impossible (empty or full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].valid && !entries[i].done &&
                        (entries[i].tag == ROB_TAG_W'(cdb_tag))) begin
                        entries[i].done <= 1'b1;
                    end
                end
            end
            if (retire) entries[head] <= '0;
            if (fire)   entries[tail] <= new_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush_now) begin
            count <= '0;
        end else if (fire && !retire) begin
            count <= count + CNT_W'(1);
        end else if (!fire && retire) begin
            count <= count - CNT_W'(1);
        end
    end

    rob_ptr_ctr #(.DEPTH(DEPTH)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush_now),
        .inc (retire),
        .ptr (head)
    );

    rob_ptr_ctr #(.DEPTH(DEPTH)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush_now),
        .inc (fire),
        .ptr (tail)
    );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: vector table, directed corner sequences, random vs queue model.
module tb_rob_commit_ctrl;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_ready;
    logic       alloc_has_dest;
    logic [4:0] alloc_dest;
    logic [3:0] alloc_tag;
    logic       cdb_valid;
    logic [3:0] cdb_tag;
    logic [3:0] new_name_in;
    logic [4:0] new_name_index;
    logic       commit;
    logic [4:0] to_zero_index;
    logic [3:0] original_name;
    logic       retire;
    logic [3:0] rob_count;
`ifdef ROB_FLUSH_EN
    logic       flush;
`endif

    int checks = 0;
    int errors = 0;

    rob_commit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ROB_FLUSH_EN
        .flush          (flush),
`endif
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_has_dest (alloc_has_dest),
        .alloc_dest     (alloc_dest),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .new_name_in    (new_name_in),
        .new_name_index (new_name_index),
        .commit         (commit),
        .to_zero_index  (to_zero_index),
        .original_name  (original_name),
        .retire         (retire),
        .rob_count      (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit av; bit hd; int dest; int tag; bit cv; int ct;
        bit e_ready; int e_nni; int e_nnin; bit e_ret; bit e_com; int e_tzi; int e_on; int e_cnt;
    } vec_t;

    typedef struct { bit hd; int dest; int tag; bit done; } mdl_t;

    vec_t vt[$];
    mdl_t mq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input bit hd, input int dest, input int tag,
                         input bit cv, input int ct);
        alloc_valid    = av;
        alloc_has_dest = hd;
        alloc_dest     = 5'(dest);
        alloc_tag      = 4'(tag);
        cdb_valid      = cv;
        cdb_tag        = 4'(ct);
    endtask

    task automatic cyc(input bit av, input bit hd, input int dest, input int tag,
                       input bit cv, input int ct);
        @(negedge clk);
        drive(av, hd, dest, tag, cv, ct);
        #1;
    endtask

    task automatic add(input bit av, input bit hd, input int dest, input int tag, input bit cv,
                       input int ct, input bit er, input int enni, input int ennin, input bit eret,
                       input bit ecom, input int etzi, input int eon, input int ecnt);
        vec_t v;
        v.av = av; v.hd = hd; v.dest = dest; v.tag = tag; v.cv = cv; v.ct = ct;
        v.e_ready = er; v.e_nni = enni; v.e_nnin = ennin; v.e_ret = eret; v.e_com = ecom;
        v.e_tzi = etzi; v.e_on = eon; v.e_cnt = ecnt;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset ready", alloc_ready, 1);
        chk("reset count", rob_count, 0);
        chk("reset retire", retire, 0);
        chk("reset commit", commit, 0);
        chk("reset tzi", to_zero_index, 0);
        chk("reset on", original_name, 0);
        chk("reset nni", new_name_index, 0);
        @(negedge clk);
        rst = 1'b0;

        //  av hd dst tag cv ct | rdy nni nnin ret com tzi on cnt
        add(1, 1, 3, 5, 0, 0,   1, 3, 5, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 5,   1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3, 5, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 2, 2, 0, 0,   1, 2, 2, 0, 0, 0, 0, 1);
        add(1, 1, 4, 3, 0, 0,   1, 4, 3, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 1, 3,   1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 2,   1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 1, 1, 3);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2, 2, 2);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 4, 3, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 7, 6, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 6,   1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 7, 1, 7,   1, 0, 7, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 7,   1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            cyc(vt[i].av, vt[i].hd, vt[i].dest, vt[i].tag, vt[i].cv, vt[i].ct);
            chk($sformatf("row%0d ready", i), alloc_ready, vt[i].e_ready);
            chk($sformatf("row%0d nni", i), new_name_index, vt[i].e_nni);
            chk($sformatf("row%0d nnin", i), new_name_in, vt[i].e_nnin);
            chk($sformatf("row%0d retire", i), retire, vt[i].e_ret);
            chk($sformatf("row%0d commit", i), commit, vt[i].e_com);
            chk($sformatf("row%0d tzi", i), to_zero_index, vt[i].e_tzi);
            chk($sformatf("row%0d on", i), original_name, vt[i].e_on);
            chk($sformatf("row%0d count", i), rob_count, vt[i].e_cnt);
        end

        // Fill to DEPTH from a non-zero pointer position, then retire while issue is held.
        for (int k = 1; k <= DEPTH; k++) cyc(1, 1, k, k, 0, 0);
        cyc(1, 1, 9, 9, 0, 0);
        chk("full count", rob_count, 8);
        chk("full ready", alloc_ready, 0);
        chk("full no issue nni", new_name_index, 0);
        chk("full no issue nnin", new_name_in, 0);
        cyc(1, 1, 9, 9, 1, 1);
        chk("full held count", rob_count, 8);
        chk("full cdb retire", retire, 0);
        cyc(1, 1, 9, 9, 0, 0);
        chk("full retire", retire, 1);
        chk("full retire commit", commit, 1);
        chk("full retire tzi", to_zero_index, 1);
        chk("full retire on", original_name, 1);
        chk("full retire ready", alloc_ready, 0);
        chk("full retire nni", new_name_index, 0);
        cyc(0, 0, 0, 0, 1, 2);
        chk("after retire count", rob_count, 7);
        chk("after retire ready", alloc_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wrap retire", retire, 1);
        chk("wrap retire tzi", to_zero_index, 2);
        chk("wrap retire on", original_name, 2);

        // Asynchronous reset mid-cycle with a retire pending.
        #2;
        rst = 1'b1;
        #1;
        chk("async rst retire", retire, 0);
        chk("async rst commit", commit, 0);
        chk("async rst count", rob_count, 0);
        chk("async rst ready", alloc_ready, 1);
        chk("async rst tzi", to_zero_index, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ROB_FLUSH_EN
        for (int k = 1; k <= 4; k++) cyc(1, 1, k, k, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("pre flush count", rob_count, 4);
        @(negedge clk);
        drive(1, 1, 9, 9, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush ready", alloc_ready, 0);
        chk("flush retire", retire, 0);
        chk("flush commit", commit, 0);
        chk("flush nni", new_name_index, 0);
        @(negedge clk);
        flush = 1'b0;
        drive(0, 0, 0, 0, 1, 2);
        #1;
        chk("post flush count", rob_count, 0);
        chk("post flush retire", retire, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("post flush commit", commit, 0);
        chk("post flush count2", rob_count, 0);
`endif

        // Randomized traffic against a queue model of the ROB.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit av, hd, cv, fire, e_ret, e_com, e_rdy;
            int dest, tag, ct, e_nni, e_nnin, e_tzi, e_on;
            av   = ($urandom % 3) != 0;
            hd   = ($urandom % 4) != 0;
            dest = $urandom % 32;
            tag  = 1 + ($urandom % 15);
            cv   = ($urandom % 2) != 0;
            if (mq.size() > 0 && ($urandom % 4) != 0)
                ct = mq[$urandom % mq.size()].tag;
            else
                ct = $urandom % 16;
            cyc(av, hd, dest, tag, cv, ct);

            e_rdy   = mq.size() != DEPTH;
            fire    = av && e_rdy;
            e_nni   = (fire && hd) ? dest : 0;
            e_nnin  = (fire && hd) ? tag : 0;
            e_ret   = mq.size() > 0 && mq[0].done;
            e_com   = e_ret && mq[0].hd && mq[0].dest != 0;
            e_tzi   = e_com ? mq[0].dest : 0;
            e_on    = e_com ? mq[0].tag : 0;
            chk("rnd ready", alloc_ready, e_rdy);
            chk("rnd nni", new_name_index, e_nni);
            chk("rnd nnin", new_name_in, e_nnin);
            chk("rnd retire", retire, e_ret);
            chk("rnd commit", commit, e_com);
            chk("rnd tzi", to_zero_index, e_tzi);
            chk("rnd on", original_name, e_on);
            chk("rnd count", rob_count, mq.size());

            if (cv) foreach (mq[j]) if (mq[j].tag == ct) mq[j].done = 1'b1;
            if (e_ret) void'(mq.pop_front());
            if (fire) begin
                mdl_t m;
                m.hd = hd; m.dest = dest; m.tag = tag; m.done = 1'b0;
                mq.push_back(m);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
